// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
//
// Purpose:
//   Captures stereo sample pairs from a synthesizer on the rising edge of a
//   level-type sample strobe, attenuates each channel by an arithmetic right
//   shift, truncates to the output width and queues the pair in a small
//   first-word-fall-through FIFO. When the FIFO is full and the consumer does
//   not pop in the same cycle the incoming pair is dropped and counted.
//
// Parameters:
//   IN_W        input sample width per channel (two's complement)
//   OUT_W       output sample width per channel, OUT_W <= IN_W
//   DEPTH_LOG2  FIFO holds 2**DEPTH_LOG2 stereo pairs (DEPTH_LOG2 >= 1)
//
// Ports:
//   clk         system clock, rising-edge
//   rst         synchronous active-high reset
//   sample      sample strobe (level); a new pair is taken on its 0->1 edge
//   left_data   signed left input sample
//   right_data  signed right input sample
//   atten       attenuation, arithmetic right shift of 0..7 bits
//   out_valid   FIFO holds at least one pair
//   out_ready   consumer accepts the head pair this cycle
//   out_left    head left sample, or last popped left sample when empty
//   out_right   head right sample, or last popped right sample when empty
//   level       current FIFO occupancy (0 .. 2**DEPTH_LOG2)
//   ovf         sticky overflow flag
//   drop_cnt    count of dropped pairs, saturating at 255
//   clr_ovf     clears ovf and drop_cnt
// -----------------------------------------------------------------------------
module sample_fifo #(
  parameter int IN_W       = 24,
  parameter int OUT_W      = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample,
  input  logic [IN_W-1:0]       left_data,
  input  logic [IN_W-1:0]       right_data,
  input  logic [2:0]            atten,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_left,
  output logic [OUT_W-1:0]      out_right,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  output logic [7:0]            drop_cnt,
  input  logic                  clr_ovf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [7:0]            DROP_MAX   = 8'hFF;

  logic                    sample_q;
  logic                    capture;

  logic signed [IN_W-1:0]  left_shift;
  logic signed [IN_W-1:0]  right_shift;
  logic [OUT_W-1:0]        left_att;
  logic [OUT_W-1:0]        right_att;

  logic                    pipe_valid;
  logic [OUT_W-1:0]        pipe_left;
  logic [OUT_W-1:0]        pipe_right;

  logic [OUT_W-1:0]        mem_left  [DEPTH];
  logic [OUT_W-1:0]        mem_right [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;

  logic [OUT_W-1:0]        hold_left;
  logic [OUT_W-1:0]        hold_right;

  logic                    full;
  logic                    pop;
  logic                    push;
  logic                    drop;

  // A capture is a rising edge of the strobe. sample_q is forced high in
  // reset so a strobe already high when reset releases is not taken as an edge.
  assign capture = sample & ~sample_q;

  // Attenuate at full input width so the sign fills in from the top, then
  // keep the most significant OUT_W bits (plain truncation, no rounding).
  assign left_shift  = $signed(left_data)  >>> atten;
  assign right_shift = $signed(right_data) >>> atten;
  assign left_att    = left_shift[IN_W-1 -: OUT_W];
  assign right_att   = right_shift[IN_W-1 -: OUT_W];

  // FIFO handshake. A pop frees the head slot in the same cycle, so a write
  // into a full FIFO is accepted when a pop happens alongside it.
  assign out_valid = (level != '0);
  assign full      = (level == FULL_LEVEL);
  assign pop       = out_valid & out_ready;
  assign push      = pipe_valid & (~full | pop);
  assign drop      = pipe_valid & full & ~pop;

  // First-word fall-through: show the head while data is queued, otherwise
  // keep showing the last pair that left the FIFO.
  assign out_left  = out_valid ? mem_left[rd_ptr]  : hold_left;
  assign out_right = out_valid ? mem_right[rd_ptr] : hold_right;

  // Edge detector and the one-deep capture stage. Strobe edges are at least
  // two cycles apart, so a single stage keeps every pair in order. Reset
  // clears the valid bit, which discards any pair that was in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q   <= 1'b1;
      pipe_valid <= 1'b0;
    end else begin
      sample_q   <= sample;
      pipe_valid <= capture;
      if (capture) begin
        pipe_left  <= left_att;
        pipe_right <= right_att;
      end
    end
  end

  // Storage array; contents need no reset because the pointers define what
  // is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_left[wr_ptr]  <= pipe_left;
      mem_right[wr_ptr] <= pipe_right;
    end
  end

  // Pointers, occupancy and the hold register for the last popped pair.
  // Pointers wrap naturally at their width; level tracks the difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      hold_left  <= '0;
      hold_right <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        hold_left  <= mem_left[rd_ptr];
        hold_right <= mem_right[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Overflow bookkeeping. A clear in the same cycle as a drop still records
  // that one drop, so no event is lost across the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      ovf      <= drop;
      drop_cnt <= {7'd0, drop};
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != DROP_MAX) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/sample_fifo.md
SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 SHALL have parameter IN_W, default 24, meaning input sample width per channel.
REQ-002 SHALL have parameter OUT_W, default 16, meaning output sample width per channel, OUT_W <= IN_W.
REQ-003 SHALL have parameter DEPTH_LOG2, default 2, meaning FIFO depth of 2**DEPTH_LOG2 stereo pairs.
REQ-004 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port sample  input  1  synthesizer sample strobe, level signal, new pair on 0->1 edge.
REQ-007 SHALL have port left_data  input  IN_W  signed left sample, two's complement.
REQ-008 SHALL have port right_data  input  IN_W  signed right sample, two's complement.
REQ-009 SHALL have port atten  input  3  attenuation, arithmetic right shift 0..7 bits.
REQ-010 SHALL have port out_valid  output  1  FIFO holds at least one pair.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head pair this cycle.
REQ-012 SHALL have port out_left  output  OUT_W  left output sample.
REQ-013 SHALL have port out_right  output  OUT_W  right output sample.
REQ-014 SHALL have port level  output  DEPTH_LOG2+1  current FIFO occupancy.
REQ-015 SHALL have port ovf  output  1  sticky overflow flag.
REQ-016 SHALL have port drop_cnt  output  8  dropped-pair count, saturating.
REQ-017 SHALL have port clr_ovf  input  1  clears ovf and drop_cnt.

Function
REQ-018 SHALL register sample into sample_q each cycle; capture event in cycle N = sample & !sample_q.
REQ-019 SHALL on capture register, at end of cycle N, per channel: (data >>> atten) sign-extended, then bits [IN_W-1 -: OUT_W]; no rounding.
REQ-020 SHALL sample atten in capture cycle only; atten changes between captures affect only later pairs.
REQ-021 SHALL write the attenuated pair into FIFO at end of cycle N+1; out_valid rises in cycle N+2 if FIFO was empty.
REQ-022 SHALL present FIFO head on out_left/out_right whenever out_valid=1 (first-word fall-through).
REQ-023 SHALL pop head at end of any cycle with out_valid & out_ready; out_ready while empty has no effect.
REQ-024 SHALL when empty drive out_left/out_right with last popped pair (hold last sample), zero if none popped since reset.
REQ-025 SHALL when full and no pop in same cycle drop incoming pair, set ovf, increment drop_cnt saturating at 255.
REQ-026 SHALL when full with simultaneous pop accept the write; no drop; level unchanged.
REQ-027 SHALL when empty with simultaneous write and out_ready not pop (out_valid still 0 that cycle).
REQ-028 SHALL wrap read/write pointers modulo 2**DEPTH_LOG2; level = write count minus read count, range 0..2**DEPTH_LOG2.
REQ-029 SHALL on clr_ovf zero ovf and drop_cnt; if a drop occurs in the same cycle, result ovf=1, drop_cnt=1.
REQ-030 SHALL keep a capture event at most one in flight; a second edge before FIFO write of the first is handled in order (pipeline, not merge).

Reset
REQ-031 SHALL while rst=1 set pointers, level, ovf, drop_cnt, hold register, pipeline valid to 0; out_valid=0, out_left=out_right=0.
REQ-032 SHALL set sample_q=1 during reset so a sample held high across reset release causes no capture.
REQ-033 SHALL discard any in-flight captured pair when rst asserts mid-operation.

Verification
REQ-034 SHALL verify: rst, atten=0, left=24'h123456, right=24'hFEDCBA, sample edge at N -> out_valid at N+2, out_left=16'h1234, out_right=16'hFEDC.
REQ-035 SHALL verify: atten=3, left=24'h800000 -> out_left=16'hF000; left=24'h7FFFFF -> 16'h0FFF.
REQ-036 SHALL verify: out_ready=0, 6 sample edges, DEPTH_LOG2=2 -> level=4, ovf=1, drop_cnt=2, popped order = first 4 pairs.
REQ-037 SHALL verify: FIFO full, write and pop same cycle -> no drop, level stays 4; then drain -> outputs hold last pair with out_valid=0.
REQ-038 SHALL verify: 300 drops -> drop_cnt=255; clr_ovf with simultaneous drop -> ovf=1, drop_cnt=1.
REQ-039 SHALL verify: sample held high through rst release -> no capture; rst asserted cycle N+1 after edge -> level=0, out_valid=0.
